// File: rtl/lane_shift_pipe.sv
// Two-stage pipelined lane shifter: stage 1 moves by s[0], stage 2 by the remaining even part of s.
// A single global enable stalls both stages; err_count saturates on out-of-range results.
module lane_shift_pipe #(
  parameter int LANE_W    = 12,
  parameter int LANES     = 8,
  parameter int SHIFT_W   = $clog2(LANES),
  parameter int MAX_SHIFT = 5,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*LANE_W-1:0]  in_data,
  input  logic [LANE_W-1:0]        in_fill,
  input  logic [SHIFT_W-1:0]       in_shift,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*LANE_W-1:0]  out_data,
  output logic                     out_err,
  output logic [CNT_W-1:0]         err_count
);

  localparam int DW = LANES * LANE_W;
  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;

  // Moves whole lanes by s; vacated lanes take the fill value in shift modes.
  function automatic logic [DW-1:0] lane_move(input logic [DW-1:0] d, input int s,
                                              input logic [1:0] m, input logic [LANE_W-1:0] f);
    logic [DW-1:0] r;
    int src;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      case (m)
        MODE_LSL: src = k - s;
        MODE_LSR: src = k + s;
        MODE_ROL: src = (k - s + LANES) % LANES;
        default:  src = (k + s) % LANES;
      endcase
      if (src >= 0 && src < LANES) r[k*LANE_W +: LANE_W] = d[src*LANE_W +: LANE_W];
      else                         r[k*LANE_W +: LANE_W] = f;
    end
    return r;
  endfunction

  logic               en;
  logic               s1_valid_q, s1_valid_d;
  logic [DW-1:0]      s1_data_q,  s1_data_d;
  logic [LANE_W-1:0]  s1_fill_q,  s1_fill_d;
  logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
  logic [1:0]         s1_mode_q,  s1_mode_d;
  logic               s1_err_q,   s1_err_d;
  logic               out_valid_q, out_valid_d;
  logic [DW-1:0]      out_data_q,  out_data_d;
  logic               out_err_q,   out_err_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_fill_d   = s1_fill_q;
    s1_shift_d  = s1_shift_q;
    s1_mode_d   = s1_mode_q;
    s1_err_d    = s1_err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s1_data_d   = lane_move(in_data, int'(in_shift[0]), in_mode, in_fill);
      s1_fill_d   = in_fill;
      // bit 0 is already applied; stage 2 moves by the even remainder
      s1_shift_d  = in_shift & ~SHIFT_W'(1);
      s1_mode_d   = in_mode;
      s1_err_d    = int'(in_shift) > MAX_SHIFT;
      out_valid_d = s1_valid_q;
      out_data_d  = lane_move(s1_data_q, int'(s1_shift_q), s1_mode_q, s1_fill_q);
      out_err_d   = s1_err_q;
    end
  end

  always_comb begin
    err_count_d = err_count_q;
    if (out_valid_q && out_ready && out_err_q && err_count_q != '1)
      err_count_d = err_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_fill_q   <= '0;
      s1_shift_q  <= '0;
      s1_mode_q   <= '0;
      s1_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_fill_q   <= s1_fill_d;
      s1_shift_q  <= s1_shift_d;
      s1_mode_q   <= s1_mode_d;
      s1_err_q    <= s1_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lane_shift_pipe.sv
// Scoreboard bench for lane_shift_pipe: driver pushes expected results, a negedge monitor pops and compares.
module tb_lane_shift_pipe;
  localparam int LANE_W  = 12;
  localparam int LANES   = 8;
  localparam int SHIFT_W = 3;
  localparam int DW      = LANES * LANE_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, out_err;
  logic [DW-1:0]     in_data, out_data;
  logic [LANE_W-1:0] in_fill;
  logic [SHIFT_W-1:0] in_shift;
  logic [1:0]        in_mode;
  logic [15:0]       err_count;
  logic              sat_in_ready, sat_out_valid, sat_out_err;
  logic [DW-1:0]     sat_out_data;
  logic [1:0]        sat_err_count;

  always #5 clk = ~clk;

  lane_shift_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_fill(in_fill), .in_shift(in_shift), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .err_count(err_count)
  );

  lane_shift_pipe #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .in_fill(in_fill), .in_shift(in_shift), .in_mode(in_mode), .out_valid(sat_out_valid),
    .out_ready(out_ready), .out_data(sat_out_data), .out_err(sat_out_err), .err_count(sat_err_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc_cyc;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_acc = 0;
  bit          chk_lat = 1'b0;
  logic [15:0] exp_cnt = '0;
  bit          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic        prev_err;

  localparam logic [DW-1:0] D    = 96'h008007006005004003002001;
  localparam logic [11:0]   FILL = 12'hABC;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input logic [11:0] f,
                                              input int s, input logic [1:0] m);
    logic [11:0]   ln[LANES];
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) ln[k] = d[k*LANE_W +: LANE_W];
    for (int k = 0; k < LANES; k++) begin
      r[k*LANE_W +: LANE_W] = f;
      case (m)
        2'b00: if (k >= s) r[k*LANE_W +: LANE_W] = ln[k-s];
        2'b01: if (k + s < LANES) r[k*LANE_W +: LANE_W] = ln[k+s];
        2'b10: r[k*LANE_W +: LANE_W] = ln[(k - s + LANES) % LANES];
        default: r[k*LANE_W +: LANE_W] = ln[(k + s) % LANES];
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      check("err_count", DW'(err_count), DW'(exp_cnt));
      check("in_ready", DW'(in_ready), DW'(!out_valid || out_ready));
      if (prev_stall) begin
        check("stall_valid", DW'(out_valid), DW'(1'b1));
        check("stall_data", out_data, prev_data);
        check("stall_err", DW'(out_err), DW'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stale_out", DW'(out_valid), DW'(1'b0));
        end else begin
          e = q.pop_front();
          check("out_data", out_data, e.data);
          check("out_err", DW'(out_err), DW'(e.err));
          if (chk_lat) check("latency", DW'(cyc), DW'(e.acc_cyc + 1));
          if (out_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_err   = out_err;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [11:0] f, input logic [2:0] s,
                      input logic [1:0] m, input logic [DW-1:0] ed, input logic ee);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1; in_data = d; in_fill = f; in_shift = s; in_mode = m;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 50) begin
        check("accept_timeout", DW'(in_ready), DW'(1'b1));
        break;
      end
    end
    if (acc) begin
      last_acc = cyc;
      q.push_back('{data: ed, err: ee, acc_cyc: cyc});
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) check("drain_timeout", DW'(q.size()), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [2:0]    rs;
    logic [1:0]    rm;
    int            prev_acc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_fill = '0; in_shift = '0; in_mode = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", DW'(out_valid), DW'(1'b0));
    check("rst_out_err", DW'(out_err), DW'(1'b0));
    check("rst_out_data", out_data, '0);
    check("rst_err_count", DW'(err_count), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(1'b1));
    @(posedge clk); #1;

    chk_lat = 1'b1;
    send(D, FILL, 3'd2, 2'b00, 96'h006005004003002001ABCABC, 1'b0);
    drain();
    send(D, FILL, 3'd3, 2'b11, 96'h003002001008007006005004, 1'b0);
    send(D, FILL, 3'd0, 2'b10, D, 1'b0);
    drain();
    send(D, FILL, 3'd7, 2'b01, 96'hABCABCABCABCABCABCABC008, 1'b1);
    send(D, FILL, 3'd6, 2'b10, 96'h002001008007006005004003, 1'b1);
    drain();
    idle(1);
    check("err_count_after_t3", DW'(err_count), DW'(2));

    chk_lat = 1'b0;
    fork
      begin
        send(D, FILL, 3'd1, 2'b00, 96'h007006005004003002001ABC, 1'b0);
        send(D, FILL, 3'd1, 2'b11, 96'h001008007006005004003002, 1'b0);
        send(D, FILL, 3'd2, 2'b01, 96'hABCABC008007006005004003, 1'b0);
        send(D, FILL, 3'd4, 2'b10, 96'h004003002001008007006005, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    chk_lat = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 16; i++) begin
      rd = {$urandom(), $urandom(), $urandom()};
      rs = 3'($urandom_range(0, 7));
      rm = 2'($urandom_range(0, 3));
      send(rd, FILL, rs, rm, ref_shift(rd, FILL, int'(rs), rm), rs > 3'd5);
      if (i > 0) check("stream_back_to_back", DW'(last_acc), DW'(prev_acc + 1));
      prev_acc = last_acc;
    end
    drain();

    rst = 1'b1; q.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++)
      send(D, FILL, 3'd6, 2'b00, 96'h002001ABCABCABCABCABCABC, 1'b1);
    drain();
    idle(1);
    check("err_count_before_rst", DW'(err_count), DW'(3));
    send(D, FILL, 3'd1, 2'b00, 96'h007006005004003002001ABC, 1'b0);
    send(D, FILL, 3'd1, 2'b00, 96'h007006005004003002001ABC, 1'b0);
    rst = 1'b1; in_valid = 1'b0; q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", DW'(out_valid), DW'(1'b0));
    check("midrst_err_count", DW'(err_count), DW'(0));
    check("midrst_in_ready", DW'(in_ready), DW'(1'b1));
    @(posedge clk); #1;
    idle(6);

    for (int i = 0; i < 5; i++)
      send(D, FILL, 3'd7, 2'b11, 96'h007006005004003002001008, 1'b1);
    drain();
    idle(1);
    check("err_count_five", DW'(err_count), DW'(5));
    check("sat_err_count", DW'(sat_err_count), DW'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
